// File: rtl/seven_seg_readback_decoder_pkg.sv
`default_nettype none
// ============================================================================
// Package     : seg_pkg
// Description : Shared constants for the seven-segment readback decoder.
//               Holds the legal active-low digit patterns (bit0=a .. bit6=g),
//               digit slot indices, the FSM state type, the seconds-tens
//               range limit and a BCD-to-binary helper.
// Revision    : 1.0 - initial release
// ============================================================================
package seg_pkg;

   // Active-low patterns, written g..a
   localparam logic [6:0] SEG_0     = 7'b1000000;
   localparam logic [6:0] SEG_1     = 7'b1111001;
   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_4     = 7'b0011001;
   localparam logic [6:0] SEG_5     = 7'b0010010;
   localparam logic [6:0] SEG_6     = 7'b0000010;
   localparam logic [6:0] SEG_7     = 7'b1111000;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0010000;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   // Digit slot indices, least significant first
   localparam logic [2:0] DIG_HUND  = 3'd0;
   localparam logic [2:0] DIG_TENTH = 3'd1;
   localparam logic [2:0] DIG_1SEC  = 3'd2;
   localparam logic [2:0] DIG_10SEC = 3'd3;
   localparam logic [2:0] DIG_1MIN  = 3'd4;
   localparam logic [2:0] DIG_10MIN = 3'd5;

   localparam logic [3:0] SECS_TENS_MAX = 4'd5;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } state_t;

   // tens*10 + ones using shifts only
   function automatic logic [6:0] bcd2bin(input logic [3:0] tens,
                                          input logic [3:0] ones);
      logic [6:0] t;
      t = {3'b000, tens};
      return (t << 3) + (t << 1) + {3'b000, ones};
   endfunction

endpackage
`default_nettype wire

// File: rtl/seven_seg_readback_decoder_digit.sv
`default_nettype none
// ============================================================================
// Module      : seg_digit_decoder
// Description : Combinational inverse of the seven-segment encoder. Maps one
//               active-low pattern to its BCD value and flags whether the
//               pattern is one of the ten legal digits.
// Ports       : i_pat   [6:0] active-low pattern, bit0=a .. bit6=g
//               o_bcd   [3:0] decoded digit (0 when illegal)
//               o_valid       1 when i_pat is a legal digit
// Revision    : 1.0 - initial release
// ============================================================================
module seg_digit_decoder
   import seg_pkg::*;
(
   input  logic [6:0] i_pat,
   output logic [3:0] o_bcd,
   output logic       o_valid
);

   always_comb begin
      o_bcd   = 4'd0;
      o_valid = 1'b1;
      case (i_pat)
         SEG_0:   o_bcd = 4'd0;
         SEG_1:   o_bcd = 4'd1;
         SEG_2:   o_bcd = 4'd2;
         SEG_3:   o_bcd = 4'd3;
         SEG_4:   o_bcd = 4'd4;
         SEG_5:   o_bcd = 4'd5;
         SEG_6:   o_bcd = 4'd6;
         SEG_7:   o_bcd = 4'd7;
         SEG_8:   o_bcd = 4'd8;
         SEG_9:   o_bcd = 4'd9;
         default: o_valid = 1'b0;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/seven_seg_readback_decoder.sv
`default_nettype none
// ============================================================================
// Module      : seven_seg_readback_decoder
// Description : Reads six active-low seven-segment digit patterns back into
//               the stopwatch's binary minutes, seconds and hundredths. One
//               shared digit decoder is stepped across a captured snapshot,
//               one digit per clock, under a start/busy/done handshake.
// Ports       : clk, rst_n          clock, async active-low reset
//               start               request, sampled only when idle
//               seg_*       [6:0]   active-low digit patterns
//               busy                decode in progress
//               done                one-cycle completion pulse
//               err                 illegal / out-of-range digit seen
//               err_digit   [2:0]   index of first failing digit
//               mins [6:0], secs [5:0], decs [6:0]  decoded values
// Revision    : 1.0 - initial release
// ============================================================================
module seven_seg_readback_decoder
   import seg_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [6:0] seg_10_mins,
   input  logic [6:0] seg_1_min,
   input  logic [6:0] seg_10_secs,
   input  logic [6:0] seg_1_sec,
   input  logic [6:0] seg_tenths,
   input  logic [6:0] seg_hundredths,
   output logic       busy,
   output logic       done,
   output logic       err,
   output logic [2:0] err_digit,
   output logic [6:0] mins,
   output logic [5:0] secs,
   output logic [6:0] decs
);

   state_t     r_state;
   logic [6:0] r_snap [0:5];
   logic [3:0] r_slot [0:5];
   logic [2:0] r_idx;
   logic       r_err_pend;
   logic [2:0] r_pend_digit;
   logic       r_done;
   logic       r_err;
   logic [2:0] r_err_digit;
   logic [6:0] r_mins;
   logic [5:0] r_secs;
   logic [6:0] r_decs;

   logic [6:0] w_pat;
   logic [3:0] w_bcd;
   logic       w_valid;
   logic       w_fail;
   logic       w_err_final;
   logic [2:0] w_err_digit_final;
   logic [6:0] w_mins;
   logic [6:0] w_secs_full;
   logic [6:0] w_decs;
   logic       w_unused_secs_msb;

   // 6:1 mux feeding the single shared decoder
   always_comb begin
      w_pat = SEG_BLANK;
      case (r_idx)
         DIG_HUND:  w_pat = r_snap[0];
         DIG_TENTH: w_pat = r_snap[1];
         DIG_1SEC:  w_pat = r_snap[2];
         DIG_10SEC: w_pat = r_snap[3];
         DIG_1MIN:  w_pat = r_snap[4];
         DIG_10MIN: w_pat = r_snap[5];
         default:   w_pat = SEG_BLANK;
      endcase
   end

   seg_digit_decoder u_dec (
      .i_pat   (w_pat),
      .o_bcd   (w_bcd),
      .o_valid (w_valid)
   );

   assign w_fail = ~w_valid | ((r_idx == DIG_10SEC) && (w_bcd > SECS_TENS_MAX));

   // The last scan step (10-mins digit) folds straight into the results so
   // that outputs, err and done all become visible in the same cycle.
   assign w_err_final       = r_err_pend | w_fail;
   assign w_err_digit_final = r_err_pend ? r_pend_digit : r_idx;

   assign w_mins      = bcd2bin(w_bcd, r_slot[4]);
   assign w_secs_full = bcd2bin(r_slot[3], r_slot[2]);
   assign w_decs      = bcd2bin(r_slot[1], r_slot[0]);
   // Seconds never exceed 59 on an error-free decode, so bit 6 is always 0
   assign w_unused_secs_msb = w_secs_full[6];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= IDLE;
         r_idx        <= 3'd0;
         r_err_pend   <= 1'b0;
         r_pend_digit <= 3'd0;
         r_done       <= 1'b0;
         r_err        <= 1'b0;
         r_err_digit  <= 3'd0;
         r_mins       <= 7'd0;
         r_secs       <= 6'd0;
         r_decs       <= 7'd0;
         for (int i = 0; i < 6; i++) begin
            r_snap[i] <= SEG_BLANK;
            r_slot[i] <= 4'd0;
         end
      end else begin
         case (r_state)
            IDLE: begin
               r_done <= 1'b0;
               if (start) begin
                  r_snap[0]    <= seg_hundredths;
                  r_snap[1]    <= seg_tenths;
                  r_snap[2]    <= seg_1_sec;
                  r_snap[3]    <= seg_10_secs;
                  r_snap[4]    <= seg_1_min;
                  r_snap[5]    <= seg_10_mins;
                  r_err        <= 1'b0;
                  r_err_digit  <= 3'd0;
                  r_err_pend   <= 1'b0;
                  r_pend_digit <= 3'd0;
                  r_idx        <= 3'd0;
                  r_state      <= SCAN;
               end
            end
            SCAN: begin
               r_slot[r_idx] <= w_bcd;
               // First failure wins; later ones leave the index untouched
               if (w_fail && !r_err_pend) begin
                  r_err_pend   <= 1'b1;
                  r_pend_digit <= r_idx;
               end
               if (r_idx == DIG_10MIN) begin
                  r_state     <= DONE;
                  r_done      <= 1'b1;
                  r_err       <= w_err_final;
                  r_err_digit <= w_err_final ? w_err_digit_final : 3'd0;
                  if (!w_err_final) begin
                     r_mins <= w_mins;
                     r_secs <= w_secs_full[5:0];
                     r_decs <= w_decs;
                  end
               end else begin
                  r_idx <= r_idx + 3'd1;
               end
            end
            DONE: begin
               r_done  <= 1'b0;
               r_state <= IDLE;
            end
            default: begin
               r_done  <= 1'b0;
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign busy      = (r_state == SCAN);
   assign done      = r_done;
   assign err       = r_err;
   assign err_digit = r_err_digit;
   assign mins      = r_mins;
   assign secs      = r_secs;
   assign decs      = r_decs;

endmodule
`default_nettype wire

// File: tb/tb_seven_seg_readback_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_seven_seg_readback_decoder
// Description : Self-checking bench for the seven-segment readback decoder.
//               A behavioural model works out each decode from the display
//               rules and tracks what the outputs should hold.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seven_seg_readback_decoder;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic [6:0] seg_10_mins = 7'h7f, seg_1_min = 7'h7f, seg_10_secs = 7'h7f;
   logic [6:0] seg_1_sec = 7'h7f, seg_tenths = 7'h7f, seg_hundredths = 7'h7f;
   logic       busy, done, err;
   logic [2:0] err_digit;
   logic [6:0] mins, decs;
   logic [5:0] secs;

   int total = 0;
   int bad   = 0;

   // tb_pat[0]=hundredths .. tb_pat[5]=10 mins
   logic [6:0] tb_pat [6];

   // model expectations
   int exp_mins = 0, exp_secs = 0, exp_decs = 0;
   bit exp_err = 0;
   int exp_err_digit = 0;

   seven_seg_readback_decoder dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .seg_10_mins(seg_10_mins), .seg_1_min(seg_1_min),
      .seg_10_secs(seg_10_secs), .seg_1_sec(seg_1_sec),
      .seg_tenths(seg_tenths), .seg_hundredths(seg_hundredths),
      .busy(busy), .done(done), .err(err), .err_digit(err_digit),
      .mins(mins), .secs(secs), .decs(decs)
   );

   always #5 clk = ~clk;

   function automatic logic [6:0] seg_of(input int d);
      case (d)
         0: return 7'b1000000;  1: return 7'b1111001;
         2: return 7'b0100100;  3: return 7'b0110000;
         4: return 7'b0011001;  5: return 7'b0010010;
         6: return 7'b0000010;  7: return 7'b1111000;
         8: return 7'b0000000;  9: return 7'b0010000;
         default: return 7'b1111111;
      endcase
   endfunction

   // Sets tb_pat from a display value; digits listed most significant first
   task automatic set_display(input int m10, input int m1, input int s10,
                              input int s1, input int t, input int h);
      tb_pat[5] = seg_of(m10); tb_pat[4] = seg_of(m1);
      tb_pat[3] = seg_of(s10); tb_pat[2] = seg_of(s1);
      tb_pat[1] = seg_of(t);   tb_pat[0] = seg_of(h);
   endtask

   task automatic apply_pat();
      seg_hundredths = tb_pat[0]; seg_tenths = tb_pat[1];
      seg_1_sec      = tb_pat[2]; seg_10_secs = tb_pat[3];
      seg_1_min      = tb_pat[4]; seg_10_mins = tb_pat[5];
   endtask

   // Reference: look each pattern up among the ten digits, then apply rules
   task automatic model_decode();
      int  d [6];
      bit  fail;
      exp_err = 0;
      exp_err_digit = 0;
      for (int i = 0; i < 6; i++) begin
         d[i] = -1;
         for (int v = 0; v < 10; v++)
            if (seg_of(v) == tb_pat[i]) d[i] = v;
         fail = (d[i] < 0) || (i == 3 && d[i] > 5);
         if (fail && !exp_err) begin
            exp_err = 1;
            exp_err_digit = i;
         end
      end
      if (!exp_err) begin
         exp_mins = d[5] * 10 + d[4];
         exp_secs = d[3] * 10 + d[2];
         exp_decs = d[1] * 10 + d[0];
      end
   endtask

   task automatic check_results(input string tag);
      total++;
      if (err !== exp_err || (exp_err && err_digit !== 3'(exp_err_digit))) begin
         bad++;
         $display("FAIL %s err: got err=%0b digit=%0d, want err=%0b digit=%0d",
                  tag, err, err_digit, exp_err, exp_err_digit);
      end
      total++;
      if (mins !== 7'(exp_mins) || secs !== 6'(exp_secs) || decs !== 7'(exp_decs)) begin
         bad++;
         $display("FAIL %s values: got %0d/%0d/%0d, want %0d/%0d/%0d",
                  tag, mins, secs, decs, exp_mins, exp_secs, exp_decs);
      end
   endtask

   // Full decode with cycle-accurate handshake checks
   task automatic run_decode(input string tag);
      model_decode();
      @(negedge clk);
      apply_pat();
      start = 1'b1;
      @(posedge clk); #1;          // cycle-0 edge: capture
      start = 1'b0;
      for (int c = 1; c <= 6; c++) begin
         total++;
         if (busy !== 1'b1 || done !== 1'b0) begin
            bad++;
            $display("FAIL %s scan cycle %0d: busy=%0b done=%0b, want busy=1 done=0",
                     tag, c, busy, done);
         end
         if (c < 6) begin
            @(posedge clk); #1;
         end
      end
      @(posedge clk); #1;          // cycle 7
      total++;
      if (done !== 1'b1 || busy !== 1'b0) begin
         bad++;
         $display("FAIL %s done cycle: done=%0b busy=%0b, want done=1 busy=0",
                  tag, done, busy);
      end
      check_results(tag);
      @(posedge clk); #1;
      total++;
      if (done !== 1'b0) begin
         bad++;
         $display("FAIL %s done pulse width: done=%0b after cycle 7, want 0", tag, done);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      total++;
      if ({busy, done, err, err_digit, mins, secs, decs} !== 26'd0) begin
         bad++;
         $display("FAIL reset: busy=%0b done=%0b err=%0b dig=%0d m=%0d s=%0d d=%0d, want all 0",
                  busy, done, err, err_digit, mins, secs, decs);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_basic();
      set_display(1, 2, 3, 4, 5, 6);
      run_decode("basic_12_34_56");
   endtask

   task automatic test_extremes();
      set_display(9, 9, 5, 9, 9, 9);
      run_decode("max_99_59_99");
      set_display(0, 0, 0, 0, 0, 0);
      run_decode("zero_00_00_00");
   endtask

   task automatic test_hold_on_error();
      set_display(1, 2, 3, 4, 5, 6);
      run_decode("load_12_34_56");
      tb_pat[1] = 7'b1111111;
      run_decode("blank_tenths");
   endtask

   task automatic test_first_fail();
      set_display(2, 0, 6, 1, 1, 1);
      tb_pat[4] = 7'b1010101;
      run_decode("first_fail");
   endtask

   task automatic test_start_while_busy();
      int ndone = 0;
      set_display(4, 7, 2, 8, 0, 3);
      model_decode();
      @(negedge clk);
      apply_pat();
      start = 1'b1;
      @(posedge clk); #1;           // edge 0
      start = 1'b0;
      for (int c = 1; c <= 14; c++) begin
         if (c == 1) begin
            set_display(8, 8, 1, 1, 1, 1);
            apply_pat();             // visible during cycle 2
         end
         start = (c == 2 || c == 4); // high during cycles 3 and 5
         @(posedge clk); #1;
         if (done === 1'b1) begin
            ndone++;
            check_results("busy_start_result");
         end
      end
      start = 1'b0;
      total++;
      if (ndone != 1) begin
         bad++;
         $display("FAIL busy_start dones: got %0d, want 1", ndone);
      end
   endtask

   task automatic test_reset_mid();
      int ndone = 0;
      set_display(3, 3, 3, 3, 3, 3);
      @(negedge clk);
      apply_pat();
      start = 1'b1;
      @(posedge clk); #1;           // edge 0
      start = 1'b0;
      repeat (3) @(posedge clk);    // now in cycle 4
      #1;
      rst_n = 1'b0;
      #1;
      exp_mins = 0; exp_secs = 0; exp_decs = 0; exp_err = 0; exp_err_digit = 0;
      total++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         bad++;
         $display("FAIL midreset handshake: busy=%0b done=%0b, want 0 0", busy, done);
      end
      check_results("midreset_outputs");
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 12; c++) begin
         @(posedge clk); #1;
         if (done === 1'b1) ndone++;
      end
      total++;
      if (ndone != 0) begin
         bad++;
         $display("FAIL midreset stray done: got %0d pulses, want 0", ndone);
      end
      set_display(5, 9, 4, 0, 7, 1);
      run_decode("after_midreset");
   endtask

   task automatic test_random();
      int dg [6];
      for (int n = 0; n < 40; n++) begin
         for (int i = 0; i < 6; i++) dg[i] = $urandom_range(9);
         dg[3] = $urandom_range(5);
         set_display(dg[5], dg[4], dg[3], dg[2], dg[1], dg[0]);
         case ($urandom_range(7))
            0: tb_pat[$urandom_range(5)] = 7'($urandom);
            1: tb_pat[3] = seg_of($urandom_range(9, 6));
            2: begin
               tb_pat[$urandom_range(5)] = 7'b1111111;
               tb_pat[$urandom_range(5)] = 7'($urandom);
            end
            default: ;
         endcase
         run_decode("random");
      end
   endtask

   initial begin
      for (int i = 0; i < 6; i++) tb_pat[i] = 7'h7f;
      test_reset();
      test_basic();
      test_extremes();
      test_hold_on_error();
      test_first_fail();
      test_start_while_busy();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/seven_seg_readback_decoder.md
# seven_seg_readback_decoder

Sequential decoder that converts six active-low seven-segment digit patterns back into the stopwatch's binary minute, second and hundredths counters. It is the inverse of the stopwatch display encoding path. It sits on the display bus as a readback and self-check block, and its results are compared against the live stopwatch counters. One shared digit decoder is time-multiplexed across the six digits under a small FSM with a start/busy/done handshake.

## Interface
Parameters:
- none; all widths are fixed by the stopwatch format.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle request; sampled only in IDLE.
- seg_10_mins, seg_1_min, seg_10_secs, seg_1_sec, seg_tenths, seg_hundredths  in  7 each  active-low patterns; bit0=a … bit6=g.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse at the end of a decode.
- err  out  1  set with done when any digit is illegal or out of range; held until the next accepted start.
- err_digit  out  3  index of the first failing digit (0=hundredths, 1=tenths, 2=1 sec, 3=10 secs, 4=1 min, 5=10 mins).
- mins  out  7  decoded minutes, 0–99.
- secs  out  6  decoded seconds, 0–59.
- decs  out  7  decoded hundredths, 0–99.

## Operation
- Legal patterns (g..a):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - Any other pattern, including blank 1111111, is illegal.
- Range rule: 10-secs digit >5 is a range error. No other digit has a range limit.
- FSM states:
  - IDLE: start=1 → capture all six inputs into a snapshot register, clear err and err_digit, set index=0, go to SCAN.
  - SCAN: decode snapshot[index] and write its BCD value to digit slot[index]. On the first illegal or range-failing digit, record err_digit and set err_pend; later failures do not overwrite err_digit. At index=5 go to DONE, otherwise increment index.
  - DONE: pulse done and drive err from err_pend. If err_pend=0, load the outputs. If err_pend=1, the outputs keep their previous values. Return to IDLE.
- Arithmetic: value = tens*10 + ones, computed as (tens<<3)+(tens<<1)+ones at 7 bits. secs is truncated to 6 bits and is always ≤59 when no error is flagged.
- start while busy: ignored; no queuing.
- Input changes after capture do not affect the result in progress.
- Reset mid-operation: FSM returns to IDLE and the partial result is discarded.

## Timing
- Reset values: busy=0, done=0, err=0, err_digit=0, mins=0, secs=0, decs=0, FSM=IDLE.
- Cycle budget, counting the start-sampling edge as cycle 0:
  - Cycle 0: inputs captured.
  - Cycles 1–6: SCAN, with busy=1.
  - Cycle 7: DONE. done=1, outputs and err valid on the edge that ends cycle 7, busy=0.
- Throughput: the earliest next start is cycle 8, giving one decode per 8 cycles.
- done and err update on the same edge. Outputs are stable between done pulses.

## Structure
- Package seg_pkg holds:
  - the ten pattern constants and SEG_BLANK;
  - digit index constants DIG_HUND to DIG_10MIN;
  - the FSM state enum {IDLE, SCAN, DONE};
  - SECS_TENS_MAX=5.
- One sub-module, seg_digit_decoder: combinational, 7-bit pattern in, 4-bit BCD out plus valid. It is instantiated once and fed by a 6:1 mux on index.
- The top level contains the FSM, the 3-bit index counter, the snapshot register, six 4-bit digit slots, the error capture logic and the BCD-to-binary adders.

## Test plan
- Display 12:34.56 (patterns 1,2,3,4,5,6), start → done at cycle 7; mins=12, secs=34, decs=56, err=0, busy high for cycles 1–6.
- Display 99:59.99 → mins=99, secs=59, decs=99. Then display 00:00.00 → all outputs 0.
- Load 12:34.56, then a second decode with tenths=1111111 → err=1, err_digit=1; outputs stay 12/34/56.
- 10-secs digit=6 and 1-min digit illegal → err=1, err_digit=3 (first failure wins).
- start pulsed at cycles 3 and 5 of a decode, with inputs changed at cycle 2 → only one done, result from the cycle-0 snapshot.
- rst_n low at cycle 4 → busy=0, done never pulses, outputs 0. A fresh start then decodes correctly.
